// File: rtl/pong_uart_cmd.sv
// pong_uart_cmd
//   Turns 4-byte UART command packets {0xA5, CMD, ARG, CHK} into pong game
//   controls. CHK must equal CMD ^ ARG. Accepted commands:
//     0x01 game start pulse, 0x02 P1 paddle, 0x03 P2 paddle, 0x04 pause.
//   Bad checksums, unknown commands and inter-byte timeouts bump a saturating
//   error counter and otherwise change nothing.
// Ports
//   i_Clk          system clock, rising edge
//   i_Reset        synchronous, active-high reset
//   i_RX_DV        one-cycle strobe qualifying i_RX_Byte
//   i_RX_Byte      received byte
//   o_Game_Start   one-cycle start pulse
//   o_Remote_*     remote paddle levels (held until changed)
//   o_Pause        pause level (held until changed)
//   o_Err_Count    saturating rejected-packet count
module pong_uart_cmd #(
  parameter int TIMEOUT_CLKS = 25000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Game_Start,
  output logic       o_Remote_Up_P1,
  output logic       o_Remote_Dn_P1,
  output logic       o_Remote_Up_P2,
  output logic       o_Remote_Dn_P2,
  output logic       o_Pause,
  output logic [7:0] o_Err_Count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GOT_HDR = 2'd1;
  localparam logic [1:0] GOT_CMD = 2'd2;
  localparam logic [1:0] GOT_ARG = 2'd3;

  localparam logic [7:0] HDR = 8'hA5;

  // Timer never exceeds TIMEOUT_CLKS-1: it expires (and clears) there.
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [7:0]    cmd_q;
  logic [7:0]    arg_q;

  logic pkt_done, chk_ok, cmd_known, exec, reject, timeout, err_inc;

  always_comb begin
    pkt_done  = i_RX_DV && (state == GOT_ARG);
    chk_ok    = (i_RX_Byte == (cmd_q ^ arg_q));
    cmd_known = (cmd_q >= 8'h01) && (cmd_q <= 8'h04);
    exec      = pkt_done && chk_ok && cmd_known;
    reject    = pkt_done && !(chk_ok && cmd_known);
    // A strobe on the expiry cycle wins: the byte is taken instead.
    timeout   = (state != IDLE) && !i_RX_DV && (timer == TMO_LAST);
    // reject needs a strobe and timeout needs none, so one increment suffices
    err_inc   = reject || timeout;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= IDLE;
      timer          <= '0;
      cmd_q          <= '0;
      arg_q          <= '0;
      o_Game_Start   <= 1'b0;
      o_Remote_Up_P1 <= 1'b0;
      o_Remote_Dn_P1 <= 1'b0;
      o_Remote_Up_P2 <= 1'b0;
      o_Remote_Dn_P2 <= 1'b0;
      o_Pause        <= 1'b0;
      o_Err_Count    <= '0;
    end else begin
      o_Game_Start <= 1'b0;

      if (err_inc && (o_Err_Count != 8'hFF))
        o_Err_Count <= o_Err_Count + 8'd1;

      if (i_RX_DV || (state == IDLE) || timeout)
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if (timeout) begin
        state <= IDLE;
      end else if (i_RX_DV) begin
        case (state)
          IDLE:    if (i_RX_Byte == HDR) state <= GOT_HDR;
          // Data bytes are stored as-is, even 0xA5: no resync on header.
          GOT_HDR: begin cmd_q <= i_RX_Byte; state <= GOT_CMD; end
          GOT_CMD: begin arg_q <= i_RX_Byte; state <= GOT_ARG; end
          default: state <= IDLE;
        endcase
      end

      // Up/down both requested (ARG[1:0]=11) means neither.
      if (exec) begin
        case (cmd_q)
          8'h01: o_Game_Start <= 1'b1;
          8'h02: begin
            o_Remote_Up_P1 <= arg_q[0] & ~arg_q[1];
            o_Remote_Dn_P1 <= arg_q[1] & ~arg_q[0];
          end
          8'h03: begin
            o_Remote_Up_P2 <= arg_q[0] & ~arg_q[1];
            o_Remote_Dn_P2 <= arg_q[1] & ~arg_q[0];
          end
          8'h04:   o_Pause <= arg_q[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_uart_cmd.sv
module tb_pong_uart_cmd;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv  = 1'b0;
  logic [7:0] rx  = 8'h00;
  logic       gs, up1, dn1, up2, dn2, pause;
  logic [7:0] err;

  int total = 0;
  int fails = 0;

  pong_uart_cmd #(.TIMEOUT_CLKS(TMO)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_RX_DV       (dv),
    .i_RX_Byte     (rx),
    .o_Game_Start  (gs),
    .o_Remote_Up_P1(up1),
    .o_Remote_Dn_P1(dn1),
    .o_Remote_Up_P2(up2),
    .o_Remote_Dn_P2(dn2),
    .o_Pause       (pause),
    .o_Err_Count   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; byte is consumed on the next rising edge and
  // the task returns on the following falling edge with dv still high.
  task automatic strobe(input logic [7:0] b);
    dv = 1'b1;
    rx = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    dv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Back-to-back packet; returns in the cycle right after the CHK edge.
  task automatic pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    strobe(8'hA5);
    strobe(c);
    strobe(a);
    strobe(k);
    dv = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // Reset with a header strobe that must be ignored.
    rst = 1'b1;
    strobe(8'hA5);
    strobe(8'hA5);
    rst = 1'b0;
    dv  = 1'b0;
    chk("rst_gs", gs, 0);
    chk("rst_pad", {up1, dn1, up2, dn2}, 4'b0000);
    chk("rst_pause", pause, 0);
    chk("rst_err", err, 0);

    // Tail of a packet with no header: silently discarded.
    strobe(8'h01); strobe(8'h00); strobe(8'h01); dv = 1'b0;
    chk("nohdr_gs", gs, 0);
    chk("nohdr_err", err, 0);

    // Start pulse, exactly one cycle.
    pkt(8'h01, 8'h00, 8'h01);
    chk("start_gs", gs, 1);
    chk("start_err", err, 0);
    idle(1);
    chk("start_gs_end", gs, 0);

    // P1 paddle rules.
    pkt(8'h02, 8'h01, 8'h03);
    chk("p1_up", {up1, dn1}, 2'b10);
    pkt(8'h02, 8'h03, 8'h01);
    chk("p1_both", {up1, dn1}, 2'b00);
    pkt(8'h02, 8'h02, 8'h00);
    chk("p1_dn", {up1, dn1}, 2'b01);

    // Bad checksum, then good pause.
    pkt(8'h04, 8'h01, 8'h00);
    chk("badchk_pause", pause, 0);
    chk("badchk_err", err, 1);
    chk("badchk_pad", {up1, dn1, up2, dn2}, 4'b0100);
    pkt(8'h04, 8'h01, 8'h05);
    chk("pause_on", pause, 1);
    chk("pause_err", err, 1);

    // Unknown command with a valid checksum.
    pkt(8'h07, 8'h03, 8'h04);
    chk("unk_err", err, 2);
    chk("unk_pause", pause, 1);

    // 0xA5-like data bytes are treated as data.
    pkt(8'h04, 8'hA4, 8'hA0);
    chk("data_pause", pause, 0);
    pkt(8'h02, 8'hA5, 8'hA7);
    chk("a5arg_p1", {up1, dn1}, 2'b10);
    chk("data_err", err, 2);

    // Timeout after A5 03.
    strobe(8'hA5); strobe(8'h03);
    idle(TMO - 1);
    chk("tmo_edge_m1", err, 2);
    idle(1);
    chk("tmo_err", err, 3);
    pkt(8'h03, 8'h02, 8'h01);
    chk("tmo_p2", {up2, dn2}, 2'b01);
    chk("tmo_after_err", err, 3);

    // Strobes landing exactly on the expiry cycle are accepted.
    strobe(8'hA5); strobe(8'h02);
    idle(TMO - 1);
    strobe(8'h02);
    idle(TMO - 1);
    strobe(8'h00);
    dv = 1'b0;
    chk("edge_p1", {up1, dn1}, 2'b01);
    chk("edge_err", err, 3);

    // Reset mid-packet: no error, no pulse, then a clean packet works.
    strobe(8'hA5); strobe(8'h01);
    dv  = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("midrst_err", err, 0);
    chk("midrst_gs", gs, 0);
    idle(1);
    chk("midrst_gs2", gs, 0);
    pkt(8'h01, 8'h00, 8'h01);
    chk("midrst_start", gs, 1);

    // Saturation with 300 bad packets, then a timeout at saturation.
    for (int i = 0; i < 300; i++) pkt(8'h04, 8'h01, 8'h00);
    chk("sat_err", err, 255);
    chk("sat_pause", pause, 0);
    strobe(8'hA5);
    idle(TMO + 2);
    chk("sat_tmo_err", err, 255);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/pong_uart_cmd.md
PONG_UART_CMD -- requirements
Module: pong_uart_cmd

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 25000, max clocks between bytes of one packet (1 ms at 25 MHz).
REQ-002 SHALL have port i_Clk  in  1  system clock (25 MHz); all logic on rising edge.
REQ-003 SHALL have port i_Reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_RX_DV  in  1  one-cycle strobe: i_RX_Byte valid, from UART receiver.
REQ-005 SHALL have port i_RX_Byte  in  8  received byte.
REQ-006 SHALL have port o_Game_Start  out  1  one-cycle pulse to the pong game start input.
REQ-007 SHALL have port o_Remote_Up_P1, o_Remote_Dn_P1, o_Remote_Up_P2, o_Remote_Dn_P2  out  1 each  remote paddle levels, ORed with switches downstream.
REQ-008 SHALL have port o_Pause  out  1  game pause level.
REQ-009 SHALL have port o_Err_Count  out  8  saturating count of rejected packets.

Function
REQ-010 SHALL parse 4-byte packets: header 0xA5, CMD, ARG, CHK, where valid CHK = CMD XOR ARG.
REQ-011 SHALL implement states IDLE, GOT_HDR, GOT_CMD, GOT_ARG; each byte is consumed only on a cycle with i_RX_DV=1.
REQ-012 SHALL, in IDLE, go to GOT_HDR on byte 0xA5 and silently discard any other byte (no error count).
REQ-013 SHALL latch CMD in GOT_HDR and ARG in GOT_CMD, storing each byte as data even if it equals 0xA5 (no resync).
REQ-014 SHALL, in GOT_ARG, compare the byte with CMD XOR ARG, return to IDLE, and execute or reject on that same clock edge.
REQ-015 SHALL update outputs on the edge that registers CHK, so the effect is visible the cycle after the CHK strobe.
REQ-016 SHALL, for CMD 0x01 with valid CHK, pulse o_Game_Start high for exactly one cycle; ARG is ignored.
REQ-017 SHALL, for CMD 0x02, set o_Remote_Up_P1=ARG[0] and o_Remote_Dn_P1=ARG[1]; if ARG[1:0]=2'b11, set both to 0.
REQ-018 SHALL, for CMD 0x03, apply the REQ-017 rule to the P2 outputs.
REQ-019 SHALL, for CMD 0x04, set o_Pause=ARG[0].
REQ-020 SHALL hold paddle and pause outputs until the next valid command that changes them.
REQ-021 SHALL count a rejected packet for a bad CHK or an unknown CMD (0x00, 0x05-0xFF) with good CHK; a rejected packet changes no output except o_Err_Count.
REQ-022 SHALL keep an inter-byte timer that clears on every i_RX_DV and increments otherwise while in a non-IDLE state.
REQ-023 SHALL, when the timer reaches TIMEOUT_CLKS-1 in a non-IDLE state, return to IDLE, discard the partial packet and count one error.
REQ-024 SHALL give i_RX_DV priority over timeout expiry in the same cycle: the byte is consumed and the timer clears.
REQ-025 SHALL saturate o_Err_Count at 255; when two error sources coincide, it increments by at most 1 per cycle.
REQ-026 SHALL need no back-pressure: each strobe is consumed in one cycle, and back-to-back strobes on consecutive cycles are handled.

Reset
REQ-027 SHALL, while i_Reset=1, force state IDLE, timer 0, o_Game_Start=0, all remote paddle outputs 0, o_Pause=0 and o_Err_Count=0.
REQ-028 SHALL, when reset is asserted mid-packet, discard the partial packet with no error counted; the first byte after reset is parsed from IDLE.
REQ-029 SHALL ignore i_RX_DV on any cycle where i_Reset=1.

Verification
REQ-030 SHALL be covered by: A5 01 00 01 -> one o_Game_Start pulse, 1 cycle after CHK strobe; o_Err_Count=0.
REQ-031 SHALL be covered by: A5 02 01 03, then A5 02 03 01 -> Up_P1=1 after first packet; Up_P1=0 and Dn_P1=0 after second.
REQ-032 SHALL be covered by: A5 04 01 00 (bad CHK) -> o_Pause stays 0; o_Err_Count=1. Then A5 04 01 05 -> o_Pause=1.
REQ-033 SHALL be covered by: A5 03, then no strobe for TIMEOUT_CLKS cycles -> return to IDLE, o_Err_Count+1; a following A5 03 02 01 sets Dn_P2=1.
REQ-034 SHALL be covered by: 300 bad packets -> o_Err_Count=255; a strobe on the exact timeout cycle -> byte accepted, no error counted.
REQ-035 SHALL be covered by: reset pulsed after A5 01 -> no error counted, no pulse; a following A5 01 00 01 -> pulse.
